// File: rtl/datapath.sv
// datapath: Mini SRC bus datapath with register file, shared bus and NOT/multiply ALU (multiplier gated by DATAPATH_MUL_EN)
module datapath (
    input  logic        Clock,
    input  logic        clear,
    input  logic        PCout,
    input  logic        Zlowout,
    input  logic        Zhighout,
    input  logic        MDRout,
    input  logic        R2out,
    input  logic        R3out,
    input  logic        MARin,
    input  logic        Zin,
    input  logic        PCin,
    input  logic        MDRin,
    input  logic        IRin,
    input  logic        Yin,
    input  logic        LOin,
    input  logic        HIin,
    input  logic        IncPC,
    input  logic        Read,
    input  logic        MUL,
    input  logic        R1in,
    input  logic        R2in,
    input  logic        R3in,
    input  logic [31:0] Mdatain,
    output logic [31:0] BusMuxOut,
    output logic [31:0] R1_q,
    output logic [31:0] R2_q,
    output logic [31:0] R3_q,
    output logic [31:0] PC_q,
    output logic [31:0] IR_q,
    output logic [31:0] MAR_q,
    output logic [31:0] MDR_q,
    output logic [31:0] Y_q,
    output logic [31:0] HI_q,
    output logic [31:0] LO_q,
    output logic [63:0] Z_q
);
    logic [63:0] alu;
    // bus source select, highest priority first, idle bus reads 0
    always_comb begin
        BusMuxOut = Zhighout ? Z_q[63:32] :
                    Zlowout  ? Z_q[31:0]  :
                    MDRout   ? MDR_q      :
                    PCout    ? PC_q       :
                    R2out    ? R2_q       :
                    R3out    ? R3_q       : 32'h0;
    end
`ifdef DATAPATH_MUL_EN
    logic [63:0] prod;
    // operands sign-extended to 64 bits so the truncated product is the full signed result
    always_comb begin
        prod = $signed({{32{Y_q[31]}}, Y_q}) * $signed({{32{BusMuxOut[31]}}, BusMuxOut});
        alu  = MUL ? prod : {32'h0, ~BusMuxOut};
    end
`else
    // NOT-only ALU; MUL is folded into a constant-zero term so it stays connected
    always_comb begin
        alu = {{32{1'b0 & MUL}}, ~BusMuxOut};
    end
`endif
    // register file: all loads on the rising edge, async active-low clear
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            R1_q  <= '0;
            R2_q  <= '0;
            R3_q  <= '0;
            PC_q  <= '0;
            IR_q  <= '0;
            MAR_q <= '0;
            MDR_q <= '0;
            Y_q   <= '0;
            HI_q  <= '0;
            LO_q  <= '0;
            Z_q   <= '0;
        end else begin
            if (R1in)  R1_q  <= BusMuxOut;
            if (R2in)  R2_q  <= BusMuxOut;
            if (R3in)  R3_q  <= BusMuxOut;
            if (IRin)  IR_q  <= BusMuxOut;
            if (MARin) MAR_q <= BusMuxOut;
            if (Yin)   Y_q   <= BusMuxOut;
            if (HIin)  HI_q  <= BusMuxOut;
            if (LOin)  LO_q  <= BusMuxOut;
            if (Zin)   Z_q   <= alu;
            if (MDRin) MDR_q <= Read ? Mdatain : BusMuxOut;
            PC_q <= IncPC ? PC_q + 32'd1 : PCin ? BusMuxOut : PC_q;
        end
    end
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: scoreboard bench for datapath; stimulus queues expectations, a negedge monitor compares
module tb_datapath;
    logic        Clock = 1'b0;
    logic        clear = 1'b0;
    logic [19:0] ctl = '0;
    logic [31:0] Mdatain = '0;
    logic PCout, Zlowout, Zhighout, MDRout, R2out, R3out, MARin, Zin, PCin, MDRin;
    logic IRin, Yin, LOin, HIin, IncPC, Read, MUL, R1in, R2in, R3in;
    logic [31:0] BusMuxOut, R1_q, R2_q, R3_q, PC_q, IR_q, MAR_q, MDR_q, Y_q, HI_q, LO_q;
    logic [63:0] Z_q;
    assign {PCout, Zlowout, Zhighout, MDRout, R2out, R3out, MARin, Zin, PCin, MDRin,
            IRin, Yin, LOin, HIin, IncPC, Read, MUL, R1in, R2in, R3in} = ctl;

    localparam logic [19:0] C_PCOUT = 20'h1 << 19, C_ZLO = 20'h1 << 18, C_ZHI = 20'h1 << 17,
        C_MDROUT = 20'h1 << 16, C_R2OUT = 20'h1 << 15, C_R3OUT = 20'h1 << 14, C_MARIN = 20'h1 << 13,
        C_ZIN = 20'h1 << 12, C_PCIN = 20'h1 << 11, C_MDRIN = 20'h1 << 10, C_IRIN = 20'h1 << 9,
        C_YIN = 20'h1 << 8, C_LOIN = 20'h1 << 7, C_HIIN = 20'h1 << 6, C_INC = 20'h1 << 5,
        C_READ = 20'h1 << 4, C_MUL = 20'h1 << 3, C_R1IN = 20'h1 << 2, C_R2IN = 20'h1 << 1,
        C_R3IN = 20'h1;
    localparam int I_R1 = 0, I_R2 = 1, I_R3 = 2, I_PC = 3, I_IR = 4, I_MAR = 5, I_MDR = 6,
        I_Y = 7, I_HI = 8, I_LO = 9, I_Z = 10, I_BUS = 11;
`ifdef DATAPATH_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    datapath dut (
        .Clock(Clock), .clear(clear), .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .MDRout(MDRout), .R2out(R2out), .R3out(R3out), .MARin(MARin), .Zin(Zin), .PCin(PCin),
        .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .LOin(LOin), .HIin(HIin), .IncPC(IncPC),
        .Read(Read), .MUL(MUL), .R1in(R1in), .R2in(R2in), .R3in(R3in), .Mdatain(Mdatain),
        .BusMuxOut(BusMuxOut), .R1_q(R1_q), .R2_q(R2_q), .R3_q(R3_q), .PC_q(PC_q), .IR_q(IR_q),
        .MAR_q(MAR_q), .MDR_q(MDR_q), .Y_q(Y_q), .HI_q(HI_q), .LO_q(LO_q), .Z_q(Z_q)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int          id;
        logic [63:0] v;
    } exp_t;
    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    string names[12] = '{"R1", "R2", "R3", "PC", "IR", "MAR", "MDR", "Y", "HI", "LO", "Z", "BUS"};

    function automatic logic [63:0] obs(input int id);
        case (id)
            I_R1:    return {32'h0, R1_q};
            I_R2:    return {32'h0, R2_q};
            I_R3:    return {32'h0, R3_q};
            I_PC:    return {32'h0, PC_q};
            I_IR:    return {32'h0, IR_q};
            I_MAR:   return {32'h0, MAR_q};
            I_MDR:   return {32'h0, MDR_q};
            I_Y:     return {32'h0, Y_q};
            I_HI:    return {32'h0, HI_q};
            I_LO:    return {32'h0, LO_q};
            I_Z:     return Z_q;
            default: return {32'h0, BusMuxOut};
        endcase
    endfunction

    // monitor: drain every queued expectation against the settled DUT state
    always @(negedge Clock) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [63:0] a;
            e = sb.pop_front();
            a = obs(e.id);
            n_cmp++;
            if (a !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", names[e.id], a, e.v);
            end
        end
    end

    task automatic expect_v(input int id, input logic [63:0] v);
        sb.push_back('{id, v});
    endtask

    task automatic step(input logic [19:0] c, input logic [31:0] md = 32'h0);
        @(negedge Clock);
        #1 ctl = c;
        Mdatain = md;
        @(posedge Clock);
        #1 ctl = '0;
    endtask

    task automatic bus_chk(input logic [19:0] c, input logic [31:0] v);
        @(negedge Clock);
        #1 ctl = c;
        expect_v(I_BUS, {32'h0, v});
        @(negedge Clock);
        #1 ctl = '0;
    endtask

    initial begin
        for (int i = 0; i < 12; i++) expect_v(i, 64'h0);
        @(negedge Clock);
        #1 clear = 1'b1;
        step(C_MDRIN | C_READ, 32'h12);     expect_v(I_MDR, 64'h12);
        step(C_MDROUT | C_R2IN);            expect_v(I_R2, 64'h12);
        step(C_MDRIN | C_READ, 32'h14);
        step(C_MDROUT | C_R3IN);            expect_v(I_R3, 64'h14);
        step(C_MDRIN | C_READ, 32'h4);
        step(C_MDROUT | C_R1IN);            expect_v(I_R1, 64'h4);
        step(C_R3OUT | C_ZIN);              expect_v(I_Z, 64'h0000_0000_FFFF_FFEB);
        step(C_ZLO | C_R1IN);               expect_v(I_R1, 64'hFFFF_FFEB);
        step(C_PCOUT | C_MARIN);            expect_v(I_MAR, 64'h0);
        step(C_INC);                        expect_v(I_PC, 64'h1);
        step(C_MDRIN | C_READ, 32'h6891_8000);
        step(C_MDROUT | C_IRIN);            expect_v(I_IR, 64'h6891_8000);
        step(C_MDRIN | C_READ, 32'hFFFF_FFFF);
        step(C_MDROUT | C_PCIN);            expect_v(I_PC, 64'hFFFF_FFFF);
        step(C_INC);                        expect_v(I_PC, 64'h0);
        step(C_INC | C_PCIN | C_MDROUT);    expect_v(I_PC, 64'h1);
        step(C_R2OUT | C_YIN);              expect_v(I_Y, 64'h12);
        step(C_R3OUT | C_MUL | C_ZIN);      expect_v(I_Z, MUL_ON ? 64'h168 : 64'hFFFF_FFEB);
        step(C_ZLO | C_LOIN);               expect_v(I_LO, MUL_ON ? 64'h168 : 64'hFFFF_FFEB);
        step(C_ZHI | C_HIIN);               expect_v(I_HI, 64'h0);
        step(C_MDRIN | C_READ, 32'hFFFF_FFFE);
        step(C_MDROUT | C_YIN);             expect_v(I_Y, 64'hFFFF_FFFE);
        step(C_MDRIN | C_READ, 32'h3);
        step(C_MDROUT | C_MUL | C_ZIN);     expect_v(I_Z, MUL_ON ? 64'hFFFF_FFFF_FFFF_FFFA : 64'hFFFF_FFFC);
        step(C_ZHI | C_HIIN);               expect_v(I_HI, MUL_ON ? 64'hFFFF_FFFF : 64'h0);
        step(C_ZLO | C_ZIN);                expect_v(I_Z, MUL_ON ? 64'h5 : 64'h3);
        bus_chk(C_MDROUT | C_R2OUT, 32'h3);
        bus_chk(C_ZHI | C_ZLO, 32'h0);
        bus_chk(C_ZLO | C_MDROUT, MUL_ON ? 32'h5 : 32'h3);
        bus_chk(C_PCOUT | C_R2OUT, 32'h1);
        bus_chk(C_R2OUT | C_R3OUT, 32'h12);
        bus_chk(20'h0, 32'h0);
        step(20'h0);                        expect_v(I_R1, 64'hFFFF_FFEB);
        step(C_MDRIN, 32'hDEAD_BEEF);       expect_v(I_MDR, 64'h0);
        step(C_MDRIN | C_READ, 32'h77);
        @(posedge Clock);
        #2 clear = 1'b0;
        ctl = C_R2OUT | C_R1IN;
        for (int i = 0; i < 12; i++) expect_v(i, 64'h0);
        @(negedge Clock);
        #1 clear = 1'b1;
        ctl = '0;
        step(C_MDRIN | C_READ, 32'h55);     expect_v(I_MDR, 64'h55);
        expect_v(I_R1, 64'h0);
        @(negedge Clock);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/datapath.md
# datapath

32-bit bus-oriented datapath for the Mini SRC processor. It holds the CPU register set (R1–R3, PC, IR, MAR, MDR, Y, 64-bit Z, HI, LO), a single shared 32-bit bus and a NOT/multiply ALU. It sits under the control unit, which drives every `*in`/`*out` strobe directly, and next to memory, which supplies read data on `Mdatain`.

## Interface
Parameters: none.

Ports:
- `Clock` — in, 1: sole clock; all registers update on its rising edge.
- `clear` — in, 1: reset, asynchronous, active-low; clears every register to 0.
- `PCout`, `Zlowout`, `Zhighout`, `MDRout`, `R2out`, `R3out` — in, 1 each: bus-source selects.
- `MARin`, `Zin`, `PCin`, `MDRin`, `IRin`, `Yin`, `LOin`, `HIin` — in, 1 each: register load enables.
- `IncPC` — in, 1: PC increment.
- `Read` — in, 1: MDR input select. 1 selects `Mdatain`; 0 selects the bus.
- `MUL` — in, 1: ALU op select. 1 = multiply; 0 = NOT.
- `R1in`, `R2in`, `R3in` — in, 1 each: general-register load enables.
- `Mdatain` — in, 32: memory read data.
- `BusMuxOut` — out, 32: current bus value.
- `R1_q`, `R2_q`, `R3_q`, `PC_q`, `IR_q`, `MAR_q`, `MDR_q`, `Y_q`, `HI_q`, `LO_q` — out, 32 each: register contents.
- `Z_q` — out, 64: Z register; bits [63:32] are Zhigh, bits [31:0] are Zlow.

The first 23 ports stay in the order listed above. The observation outputs are appended after `Mdatain`.

## Operation
- **Bus.** The bus is combinational, with one source per cycle.
  - Priority when several sources are asserted: `Zhighout` > `Zlowout` > `MDRout` > `PCout` > `R2out` > `R3out`.
  - With no source asserted, the bus is 0.
  - Zhigh = Z[63:32]; Zlow = Z[31:0].
- **Register loads.** R1/R2/R3/MAR/IR/Y/HI/LO load the bus when their `*in` strobe is high.
- **MDR.** When `MDRin` is high, MDR loads `Read ? Mdatain : bus`.
- **PC.** `IncPC` has priority: PC ← PC + 1, mod 2^32, wrapping 0xFFFFFFFF → 0. Otherwise, when `PCin` is high, PC ← bus.
- **ALU.** Combinational. Operand A = Y; operand B = bus.
  - `MUL`=0: result = {32'h0, ~B}.
  - `MUL`=1: result = signed(A) × signed(B), full 64-bit product.
- **Z.** When `Zin` is high, Z ← ALU result.
- **Read-before-write.** A register may be both bus source and destination in one cycle; it captures the pre-edge bus value.
- **Unmapped strobes.** There are no R1out, HIout, LOout or MARout bus sources. These registers are observable only through the `*_q` ports.

## Timing
- All loads happen on the rising `Clock` edge.
- The bus and ALU settle within the same cycle, so a single cycle with `R3out`+`Zin` captures ~R3 at the next edge.
- Latency:
  - One register transfer = 1 cycle.
  - ALU op into Z, then Z to a register = 2 cycles.
- `clear` low forces all registers and `*_q` outputs to 0 immediately, independent of `Clock`.
  - Asserted mid-transfer, it discards the pending load.
  - The first load after deassertion happens on the next rising edge at which `clear` is high.
- With no strobes asserted, registers hold indefinitely.
- `Mdatain` is sampled only at an edge where `MDRin`=1 and `Read`=1.

## Configuration
- `DATAPATH_MUL_EN` defined: the multiply path is present and `MUL` selects it.
- `DATAPATH_MUL_EN` undefined:
  - No multiplier is synthesized and `MUL` is ignored.
  - The ALU always produces {32'h0, ~B}.
  - HI/LO and `Zhighout` remain functional; Zhigh is always 0 after a Z load.

## Test plan
1. **Reset.** Load nonzero values, then pulse `clear`=0 between edges → every `*_q` = 0 at once and `BusMuxOut` = 0.
2. **Register load.**
   - `Mdatain`=0x12 with `Read`=1, `MDRin`=1 for one edge → MDR = 0x12.
   - Next cycle, `MDRout`=1, `R2in`=1 → R2 = 0x12.
   - Same sequence with 0x14 → R3; with 0x4 → R1.
3. **NOT.** R3 = 0x14.
   - `R3out`+`Zin` with `MUL`=0 → Z = 0x00000000_FFFFFFEB.
   - Then `Zlowout`+`R1in` → R1 = 0xFFFFFFEB.
4. **Fetch.** PC = 0.
   - `PCout`+`MARin` → MAR = 0.
   - `IncPC` → PC = 1.
   - `Mdatain`=0x68918000 with `Read`+`MDRin`, then `MDRout`+`IRin` → IR = 0x68918000.
   - PC = 0xFFFFFFFF with `IncPC` → PC = 0.
5. **Multiply (macro on).**
   - R2 = 0x12: `R2out`+`Yin` → Y = 0x12. Then `R3out`+`MUL`+`Zin` → Z = 0x168.
   - `Zlowout`+`LOin` → LO = 0x168; `Zhighout`+`HIin` → HI = 0.
   - Y = 0xFFFFFFFE with B = 3 → Z = 0xFFFFFFFF_FFFFFFFA.
   - Macro off: the same stimulus gives Z = {0, ~B}.
6. **Bus priority.**
   - `MDRout`+`R2out` together → bus = MDR.
   - `Zhighout`+`Zlowout` together → bus = Z[63:32].
   - No source asserted → bus = 0.
